snn_batch_sequencer: RTL and testbench

Hardware batch controller for the binary SNN inference cores (`snn_fc_top` instances), one core per pre-loaded sample. On a host request it runs the samples one at a time. For each sample it resets the cores, gives the selected core a one-cycle start, waits for that core's done, and captures its 1-bit class. It replaces the simulation-only sample loop so that batch inference runs on the FPGA without a testbench. It keeps the per-sample result, valid and timeout vectors plus a count of "Turning" results.

---
 rtl/snn_pkg.sv | 23 ++
 rtl/snn_timeout_counter.sv | 37 +++
 rtl/snn_batch_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_snn_batch_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// ----------------------------------------------------------------------------
// snn_pkg
// Shared types and constants for the SNN batch controller.
//   seq_state_t    : batch sequencer FSM state encoding
//   CLASS_STRAIGHT : predicted_class value 0
//   CLASS_TURNING  : predicted_class value 1 (the class that is counted)
// ----------------------------------------------------------------------------
package snn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        SETTLE,
        START,
        WAIT,
        CAPTURE,
        FIN
    } seq_state_t;

    localparam logic CLASS_STRAIGHT = 1'b0;
    localparam logic CLASS_TURNING  = 1'b1;

endpackage

// File: rtl/snn_timeout_counter.sv
// ----------------------------------------------------------------------------
// snn_timeout_counter
// Loadable down-counter used to bound how long a sample may wait for done.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   load_i     : load load_val_i into the counter (has priority over en_i)
//   load_val_i : value to load
//   en_i       : decrement by one while the count is non-zero
//   expired_o  : high while the count is zero
// ----------------------------------------------------------------------------
module snn_timeout_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/snn_batch_sequencer.sv
// ----------------------------------------------------------------------------
// snn_batch_sequencer
// Runs a batch of pre-loaded samples on the attached SNN cores one at a time:
// reset all cores, start the selected core, wait for its done (bounded by a
// timeout), capture its class, then move to the next sample.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   batch_start   : single-cycle batch request (only honoured in IDLE)
//   batch_len     : number of samples, clamped to NUM_CORES
//   busy          : high in every state except IDLE
//   batch_done    : one-cycle pulse at the end of a batch
//   cur_idx       : index of the sample in flight
//   core_rst      : shared reset to all cores
//   core_start    : one-hot single-cycle start pulse
//   core_done     : per-core done level
//   core_class    : per-core predicted class
//   results       : captured class per sample
//   valid_mask    : sample completed normally
//   timeout_mask  : sample was abandoned after the timeout
//   class1_count  : number of valid results equal to CLASS_TURNING
// ----------------------------------------------------------------------------
module snn_batch_sequencer
    import snn_pkg::*;
#(
    parameter int NUM_CORES       = 200,
    parameter int TIMEOUT_CYCLES  = 65535,
    parameter int CORE_RST_CYCLES = 2,
    parameter int IDX_W           = $clog2(NUM_CORES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 batch_start,
    input  logic [IDX_W-1:0]     batch_len,
    output logic                 busy,
    output logic                 batch_done,
    output logic [IDX_W-1:0]     cur_idx,
    output logic                 core_rst,
    output logic [NUM_CORES-1:0] core_start,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic [NUM_CORES-1:0] core_class,
    output logic [NUM_CORES-1:0] results,
    output logic [NUM_CORES-1:0] valid_mask,
    output logic [NUM_CORES-1:0] timeout_mask,
    output logic [IDX_W-1:0]     class1_count
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RST_W = $clog2(CORE_RST_CYCLES + 1);

    localparam logic [IDX_W-1:0] NUM_CORES_W = IDX_W'(NUM_CORES);
    localparam logic [CNT_W-1:0] TMO_LOAD    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RST_W-1:0] RST_LOAD    = RST_W'(CORE_RST_CYCLES - 1);

    seq_state_t             state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       len_q;
    logic [RST_W-1:0]       rst_cnt_q;
    logic                   busy_q;
    logic                   batch_done_q;
    logic                   core_rst_q;
    logic [NUM_CORES-1:0]   core_start_q;
    logic [NUM_CORES-1:0]   results_q;
    logic [NUM_CORES-1:0]   valid_q;
    logic [NUM_CORES-1:0]   timeout_q;
    logic [IDX_W-1:0]       class1_q;

    logic [NUM_CORES-1:0]   sel_onehot;
    logic                   sel_done;
    logic                   sel_class;
    logic                   tmo_expired;
    logic [IDX_W-1:0]       len_clamped;
    logic [IDX_W-1:0]       idx_d;

    // One-hot decode of the current index; selecting through a mask keeps
    // non-selected cores' done/class out of the decision.
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_sel
        assign sel_onehot[gi] = (idx_q == IDX_W'(gi));
    end

    assign sel_done    = |(core_done & sel_onehot);
    assign sel_class   = |(core_class & sel_onehot);
    assign len_clamped = (batch_len > NUM_CORES_W) ? NUM_CORES_W : batch_len;
    assign idx_d       = idx_q + IDX_W'(1);

    // Loaded with TIMEOUT_CYCLES-1 in START, so it reads zero on the
    // TIMEOUT_CYCLES-th WAIT cycle.
    snn_timeout_counter #(
        .WIDTH (CNT_W)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == START),
        .load_val_i (TMO_LOAD),
        .en_i       (state_q == WAIT),
        .expired_o  (tmo_expired)
    );

    // Outputs are set on the edge that enters the state they belong to, so
    // they are registered and line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            rst_cnt_q    <= '0;
            busy_q       <= 1'b0;
            batch_done_q <= 1'b0;
            core_rst_q   <= 1'b0;
            core_start_q <= '0;
            results_q    <= '0;
            valid_q      <= '0;
            timeout_q    <= '0;
            class1_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (batch_start) begin
                        len_q     <= len_clamped;
                        idx_q     <= '0;
                        results_q <= '0;
                        valid_q   <= '0;
                        timeout_q <= '0;
                        class1_q  <= '0;
                        busy_q    <= 1'b1;
                        if (len_clamped == '0) begin
                            state_q      <= FIN;
                            batch_done_q <= 1'b1;
                        end else begin
                            state_q    <= CRST;
                            core_rst_q <= 1'b1;
                            rst_cnt_q  <= RST_LOAD;
                        end
                    end
                end
                CRST: begin
                    if (rst_cnt_q == '0) begin
                        state_q    <= SETTLE;
                        core_rst_q <= 1'b0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - RST_W'(1);
                    end
                end
                SETTLE: begin
                    state_q      <= START;
                    core_start_q <= sel_onehot;
                end
                START: begin
                    state_q      <= WAIT;
                    core_start_q <= '0;
                end
                WAIT: begin
                    // done is checked first so it wins over a same-cycle timeout
                    if (sel_done) begin
                        results_q <= results_q | (sel_onehot & {NUM_CORES{sel_class}});
                        valid_q   <= valid_q | sel_onehot;
                        if (sel_class == CLASS_TURNING) begin
                            class1_q <= class1_q + IDX_W'(1);
                        end
                        state_q <= CAPTURE;
                    end else if (tmo_expired) begin
                        timeout_q <= timeout_q | sel_onehot;
                        state_q   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    idx_q <= idx_d;
                    if (idx_d == len_q) begin
                        state_q      <= FIN;
                        batch_done_q <= 1'b1;
                    end else begin
                        state_q    <= CRST;
                        core_rst_q <= 1'b1;
                        rst_cnt_q  <= RST_LOAD;
                    end
                end
                FIN: begin
                    state_q      <= IDLE;
                    batch_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign batch_done   = batch_done_q;
    assign cur_idx      = idx_q;
    assign core_rst     = core_rst_q;
    assign core_start   = core_start_q;
    assign results      = results_q;
    assign valid_mask   = valid_q;
    assign timeout_mask = timeout_q;
    assign class1_count = class1_q;

endmodule

// File: tb/tb_snn_batch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_snn_batch_sequencer
// Directed batches against stub cores (per-core done delay and class).
// Expected start pulses (index + start-to-next-reset gap) and per-batch
// result vectors are queued when a batch is issued; a negedge monitor pops
// and compares whenever the DUT pulses core_start or batch_done.
// ----------------------------------------------------------------------------
module tb_snn_batch_sequencer;

    localparam int NC   = 4;
    localparam int TMO  = 16;
    localparam int RSTC = 2;
    localparam int IW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          batch_start;
    logic [IW-1:0] batch_len;
    logic          busy;
    logic          batch_done;
    logic [IW-1:0] cur_idx;
    logic          core_rst;
    logic [NC-1:0] core_start;
    logic [NC-1:0] core_done;
    logic [NC-1:0] core_class;
    logic [NC-1:0] results;
    logic [NC-1:0] valid_mask;
    logic [NC-1:0] timeout_mask;
    logic [IW-1:0] class1_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    snn_batch_sequencer #(
        .NUM_CORES       (NC),
        .TIMEOUT_CYCLES  (TMO),
        .CORE_RST_CYCLES (RSTC),
        .IDX_W           (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .batch_start  (batch_start),
        .batch_len    (batch_len),
        .busy         (busy),
        .batch_done   (batch_done),
        .cur_idx      (cur_idx),
        .core_rst     (core_rst),
        .core_start   (core_start),
        .core_done    (core_done),
        .core_class   (core_class),
        .results      (results),
        .valid_mask   (valid_mask),
        .timeout_mask (timeout_mask),
        .class1_count (class1_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stub cores ----------------
    // dly[i]=N: done visible N cycles after the start cycle; 0 = never.
    int            dly [NC];
    logic [NC-1:0] cls;
    int            scnt [NC];
    logic [NC-1:0] armed;

    assign core_class = cls;

    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (rst || core_rst) begin
                core_done[i] <= 1'b0;
                armed[i]     <= 1'b0;
            end else if (core_start[i]) begin
                armed[i]     <= 1'b1;
                scnt[i]      <= 1;
                core_done[i] <= (dly[i] == 1);
            end else if (armed[i] && !core_done[i] && dly[i] != 0) begin
                scnt[i] <= scnt[i] + 1;
                if (scnt[i] + 1 == dly[i]) core_done[i] <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int          exp_idx[$];
    int          exp_gap[$];
    logic [15:0] exp_b[$];   // {results, valid, timeout, class1_count}

    int  pend_start;
    int  pend_gap;
    bit  pend = 0;

    always @(negedge clk) begin
        int          ei;
        logic [NC-1:0] oh;
        logic [15:0] eb;
        if (rst) begin
            pend = 0;
        end else begin
            if (pend && (core_rst || batch_done)) begin
                checks++;
                if (cyc - pend_start != pend_gap) begin
                    errors++;
                    $display("FAIL wait_gap: got %0d cycles, expected %0d", cyc - pend_start, pend_gap);
                end
                pend = 0;
            end
            if (core_start != '0) begin
                checks++;
                if (exp_idx.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start: core_start=%b, expected none", core_start);
                end else begin
                    ei = exp_idx.pop_front();
                    oh = 4'b0001 << ei;
                    pend_gap   = exp_gap.pop_front();
                    pend_start = cyc;
                    pend       = 1;
                    if (core_start != oh) begin
                        errors++;
                        $display("FAIL start_idx: core_start=%b, expected %b", core_start, oh);
                    end else begin
                        $display("start core %0d at cycle %0d", ei, cyc);
                    end
                end
            end
            if (batch_done) begin
                checks++;
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: batch_done with no batch pending");
                end else begin
                    eb = exp_b.pop_front();
                    if ({results, valid_mask, timeout_mask, class1_count} != eb) begin
                        errors++;
                        $display("FAIL batch_result: res=%b vld=%b tmo=%b cnt=%0d, expected res=%b vld=%b tmo=%b cnt=%0d",
                                 results, valid_mask, timeout_mask, class1_count,
                                 eb[15:12], eb[11:8], eb[7:4], eb[3:0]);
                    end else begin
                        $display("batch done res=%b vld=%b tmo=%b cnt=%0d", results, valid_mask, timeout_mask, class1_count);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic set_cores(input int d0, input int d1, input int d2, input int d3, input logic [3:0] c);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
        cls = c;
    endtask

    task automatic expect_starts(input int n);
        for (int i = 0; i < n; i++) begin
            exp_idx.push_back(i);
            exp_gap.push_back((((dly[i] == 0) || (dly[i] > TMO)) ? TMO : dly[i]) + 2);
        end
    endtask

    task automatic pulse_start(input logic [IW-1:0] len);
        @(posedge clk); #1;
        batch_len   = len;
        batch_start = 1'b1;
        @(posedge clk); #1;
        batch_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 1000) begin
            @(negedge clk);
            if (batch_done) seen = 1;
            n++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: batch_done not seen within %0d cycles, expected a pulse", name, n);
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [31:0] v;
        v = {busy, batch_done, cur_idx, core_rst, core_start, results, valid_mask, timeout_mask, class1_count};
        checks++;
        if (v != '0) begin
            errors++;
            $display("FAIL %s: outputs=%h, expected 0", name, v);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int cnt;
        rst         = 1'b1;
        batch_start = 1'b0;
        batch_len   = '0;
        set_cores(0, 0, 0, 0, 4'b0000);
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset_state");
        rst = 1'b0;

        // 1: all four cores answer after 10 cycles, classes 1,0,1,1
        set_cores(10, 10, 10, 10, 4'b1101);
        expect_starts(4);
        exp_b.push_back({4'b1101, 4'b1111, 4'b0000, 4'd3});
        pulse_start(4);
        wait_done("batch1");

        // 2: core 2 never answers -> timeout after exactly TMO WAIT cycles
        set_cores(10, 10, 0, 10, 4'b0111);
        expect_starts(4);
        exp_b.push_back({4'b0011, 4'b1011, 4'b0100, 4'd2});
        pulse_start(4);
        wait_done("batch_timeout");

        // 3: len 0 -> straight to FIN, result vectors cleared
        exp_b.push_back(16'h0000);
        pulse_start(0);
        check_bit("len0_busy", busy, 1'b1);
        check_bit("len0_done", batch_done, 1'b1);
        check_bit("len0_core_rst", core_rst, 1'b0);
        @(posedge clk); #1;
        check_bit("len0_busy_after", busy, 1'b0);
        check_bit("len0_done_after", batch_done, 1'b0);

        // 4: len 9 clamped to 4 cores
        set_cores(3, 5, 7, 2, 4'b1000);
        expect_starts(4);
        exp_b.push_back({4'b1000, 4'b1111, 4'b0000, 4'd1});
        pulse_start(9);
        wait_done("batch_clamp");

        // 5: reset during WAIT of idx 1
        set_cores(4, 0, 0, 0, 4'b0000);
        expect_starts(2);
        pulse_start(4);
        n = 0;
        while (!core_start[1] && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!core_start[1]) begin
            errors++;
            $display("FAIL idx1_start: core_start[1] not seen, expected a pulse");
        end
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_all_zero("reset_mid_batch");
        @(posedge clk); #1 rst = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (batch_done || busy) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL no_done_after_reset: %0d active cycles, expected 0", cnt);
        end
        $display("reset mid-batch applied");

        // 5b: clean run after the reset
        set_cores(6, 6, 0, 0, 4'b0010);
        expect_starts(2);
        exp_b.push_back({4'b0010, 4'b0011, 4'b0000, 4'd1});
        pulse_start(2);
        wait_done("batch_after_reset");

        // 6: done on the last timeout cycle, extra batch_start while busy
        set_cores(16, 5, 0, 0, 4'b0011);
        expect_starts(2);
        exp_b.push_back({4'b0011, 4'b0011, 4'b0000, 4'd2});
        pulse_start(2);
        repeat (8) @(posedge clk);
        #1 batch_len = 3; batch_start = 1'b1;
        @(posedge clk); #1 batch_start = 1'b0;
        wait_done("batch_edge_done");
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL busy_start_ignored: busy for %0d cycles, expected 0", cnt);
        end

        checks++;
        if (exp_idx.size() != 0 || exp_b.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: starts=%0d batches=%0d, expected 0", exp_idx.size(), exp_b.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
